imm_encoder_loader: RTL

Inverse of the decode-side immediate extension path. It accepts an opcode, register fields, a 16-bit immediate and an encoding mode. It checks that the immediate fits the selected narrow field, packs a 16-bit instruction word, and writes it into instruction memory at an auto-incrementing address. Used by the boot/test-program loader to build instruction images for the core.

---
 rtl/imm_encoder_loader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/imm_encoder_loader.sv
// Immediate encoder/loader: range-checks an immediate for the selected field mode,
// packs a 16-bit instruction word and writes it to instruction memory at an auto-incrementing address.
module imm_encoder_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          ADDR_STEP = 2,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_mode,
  input  logic [4:0]  opcode,
  input  logic [2:0]  rs,
  input  logic [2:0]  rd,
  input  logic [15:0] imm,
  input  logic        clr,
  output logic        mem_wr_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        full,
  output logic [8:0]  word_cnt
);

  localparam logic [15:0] STEP    = 16'(ADDR_STEP);
  localparam logic [8:0]  MAX_CNT = 9'(MAX_WORDS);

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, ERROR, FULL} state_t;

  state_t      state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [4:0]  opcode_q, opcode_d;
  logic [2:0]  rs_q, rs_d, rd_q, rd_d;
  logic [15:0] imm_q, imm_d;
  logic [15:0] ptr_q, ptr_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] addr_q, addr_d, data_q, data_d;
  logic        err_q, err_d, full_q, full_d;
  logic [1:0]  code_q, code_d;

  logic        legal, fits;
  logic [15:0] packed_word;

  // Sign-extended fields are legal when every bit above the field's sign bit matches it.
  always_comb begin
    legal       = 1'b1;
    fits        = 1'b0;
    packed_word = 16'h0000;
    case (mode_q)
      3'd0: begin
        fits        = ~|imm_q[15:5];
        packed_word = {opcode_q, rs_q, rd_q, imm_q[4:0]};
      end
      3'd1: begin
        fits        = (&imm_q[15:4]) | ~(|imm_q[15:4]);
        packed_word = {opcode_q, rs_q, rd_q, imm_q[4:0]};
      end
      3'd2: begin
        fits        = ~|imm_q[15:8];
        packed_word = {opcode_q, rs_q, imm_q[7:0]};
      end
      3'd3: begin
        fits        = (&imm_q[15:7]) | ~(|imm_q[15:7]);
        packed_word = {opcode_q, rs_q, imm_q[7:0]};
      end
      3'd4: begin
        fits        = (&imm_q[15:10]) | ~(|imm_q[15:10]);
        packed_word = {opcode_q, imm_q[10:0]};
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    opcode_d = opcode_q;
    rs_d     = rs_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;
    code_d   = code_q;
    full_d   = full_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          ptr_d = BASE_ADDR;
          cnt_d = 9'd0;
        end else if (in_valid) begin
          mode_d   = imm_mode;
          opcode_d = opcode;
          rs_d     = rs;
          rd_d     = rd;
          imm_d    = imm;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (!legal) begin
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = ERROR;
        end else if (!fits) begin
          err_d   = 1'b1;
          code_d  = 2'd1;
          state_d = ERROR;
        end else begin
          wr_en_d = 1'b1;
          addr_d  = ptr_q;
          data_d  = packed_word;
          state_d = WRITE;
        end
      end
      WRITE: begin
        ptr_d = ptr_q + STEP;
        cnt_d = cnt_q + 9'd1;
        if (cnt_q + 9'd1 == MAX_CNT) begin
          full_d  = 1'b1;
          state_d = FULL;
        end else begin
          state_d = IDLE;
        end
      end
      ERROR: begin
        if (clr) begin
          err_d   = 1'b0;
          code_d  = 2'd0;
          state_d = IDLE;
        end
      end
      FULL: begin
        if (clr) begin
          ptr_d   = BASE_ADDR;
          cnt_d   = 9'd0;
          full_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = 2'd0;
          state_d = IDLE;
        end else if (in_valid) begin
          err_d  = 1'b1;
          code_d = 2'd2;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 3'd0;
      opcode_q <= 5'd0;
      rs_q     <= 3'd0;
      rd_q     <= 3'd0;
      imm_q    <= 16'h0000;
      ptr_q    <= BASE_ADDR;
      cnt_q    <= 9'd0;
      wr_en_q  <= 1'b0;
      addr_q   <= BASE_ADDR;
      data_q   <= 16'h0000;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      opcode_q <= opcode_d;
      rs_q     <= rs_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= err_d;
      code_q   <= code_d;
      full_q   <= full_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_wr_en = wr_en_q;
  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign full      = full_q;
  assign word_cnt  = cnt_q;

endmodule
